random_block_gen_n: RTL

Parametrised successor to the fixed 8×8 random block generator in the blocks game. Every `gene_time` enabled cycles it scrolls a ROWS×COLS occupancy frame down one row and drops one new block into the top row. The block's column comes from the external `random` input or from an internal 16-bit LFSR. It also clears cells on player hits and counts blocks that fall off the bottom. `Disp_num` feeds the display/scan logic directly.

---
 rtl/block_gen_pkg.sv | 22 ++
 rtl/random_block_gen_n_lfsr16.sv | 37 +++
 rtl/random_block_gen_n.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/block_gen_pkg.sv
// -----------------------------------------------------------------------------
// block_gen_pkg
// Shared constants for the block-game random block generator: the LFSR width,
// its feedback tap mask, the default seed, and a small index-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package block_gen_pkg;

   localparam int LFSR_W = 16;

   // Taps for x^16+x^14+x^13+x^11+1 seen from a left-shifting register:
   // feedback = b15 ^ b13 ^ b12 ^ b10.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

   // Bits needed to index n items, never less than one bit.
   function automatic int idxWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/random_block_gen_n_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR that shifts left and inserts the XOR of the tap bits
// at bit 0. Advances only while en is high.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-low reset, loads SEED
//   en   in   advance enable
//   q    out  current register value
// -----------------------------------------------------------------------------
module lfsr16
   import block_gen_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] q
);

   logic [LFSR_W-1:0] r_q;
   logic              w_fb;

   assign w_fb = ^(r_q & LFSR_TAPS);
   assign q    = r_q;

   // The seed must be nonzero, otherwise the register locks at all zeros.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= SEED;
      end else if (en) begin
         r_q <= {r_q[LFSR_W-2:0], w_fb};
      end
   end

endmodule

// File: rtl/random_block_gen_n.sv
// -----------------------------------------------------------------------------
// random_block_gen_n
// Scrolling ROWS x COLS occupancy frame for the blocks game. Every
// max(gene_time,1) enabled cycles the frame moves down one row and a new block
// is dropped into the top row, in a column taken either from the external
// random input or from an internal LFSR. Player hits clear the lowest block
// of a column; blocks pushed out of the bottom are counted as misses.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   en         in   run enable (freezes tick counter and LFSR when low)
//   gene_time  in   cycles per step, 0 behaves as 1
//   mode       in   column source: 0 = random input, 1 = LFSR
//   random     in   external column index
//   hit_valid  in   one-cycle hit request
//   hit_col    in   column of the hit
//   Disp_num   out  frame, bit r*COLS+c = row r (0 = top), column c
//   gen_pulse  out  one cycle high with each newly stepped frame
//   hit_ack    out  one cycle high when a hit cleared a cell
//   miss       out  one cycle high when a step dropped a nonempty bottom row
//   miss_cnt   out  saturating miss total
// -----------------------------------------------------------------------------
module random_block_gen_n
   import block_gen_pkg::*;
#(
   parameter int                COLS   = 8,
   parameter int                ROWS   = 8,
   parameter int                CNT_W  = 32,
   parameter int                MISS_W = 4,
   parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
   localparam int               CI_W   = idxWidth(COLS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [CNT_W-1:0]     gene_time,
   input  logic                 mode,
   input  logic [CI_W-1:0]      random,
   input  logic                 hit_valid,
   input  logic [CI_W-1:0]      hit_col,
   output logic [ROWS*COLS-1:0] Disp_num,
   output logic                 gen_pulse,
   output logic                 hit_ack,
   output logic                 miss,
   output logic [MISS_W-1:0]    miss_cnt
);

   logic [ROWS-1:0][COLS-1:0] r_frame;
   logic [CNT_W-1:0]          r_cnt;
   logic                      r_gen;
   logic                      r_ack;
   logic                      r_miss;
   logic [MISS_W-1:0]         r_missCnt;

   logic [CNT_W-1:0]          w_limit;
   logic                      w_step;
   logic [15:0]               w_lfsr;
   logic                      w_unusedLfsr;
   logic [CI_W-1:0]           w_col;
   logic                      w_hitFound;
   logic [ROWS-1:0]           w_hitRowOH;
   logic [ROWS-1:0][COLS-1:0] w_postHit;
   logic [ROWS-1:0][COLS-1:0] w_stepped;
   logic [COLS-1:0]           w_insert;
   logic                      w_bottomFull;

   lfsr16 #(
      .SEED (SEED)
   ) uLfsr (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .q   (w_lfsr)
   );

   // Only the low CI_W bits pick the column; the rest just keep the sequence long.
   assign w_unusedLfsr = ^w_lfsr;

   // A period of 0 or 1 both mean "step every enabled edge", so the compare
   // limit is clamped at 0. Using >= rather than == means lowering gene_time
   // below the running count triggers a step at once instead of wrapping.
   assign w_limit = (gene_time == '0) ? '0 : gene_time - CNT_W'(1);
   assign w_step  = en && (r_cnt >= w_limit);

   // The LFSR column uses the value before this edge's advance.
   assign w_col    = mode ? w_lfsr[CI_W-1:0] : random;
   assign w_insert = COLS'(1) << w_col;

   // Priority search down the hit column: the last matching row in the loop
   // is the lowest block on screen, which is the one the player hits.
   always_comb begin
      w_hitFound = 1'b0;
      w_hitRowOH = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (hit_valid && r_frame[r][hit_col]) begin
            w_hitFound    = 1'b1;
            w_hitRowOH    = '0;
            w_hitRowOH[r] = 1'b1;
         end
      end
      w_postHit = r_frame;
      for (int r = 0; r < ROWS; r++) begin
         if (w_hitRowOH[r]) begin
            w_postHit[r][hit_col] = 1'b0;
         end
      end
   end

   // The step works on the post-hit frame, so a block shot out of the bottom
   // row on the same edge never counts as a miss.
   assign w_stepped    = {w_postHit[ROWS-2:0], w_insert};
   assign w_bottomFull = |w_postHit[ROWS-1];

   // Frame, pulses and tick counter. Reset wins over any pending step or hit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_frame <= '0;
         r_cnt   <= '0;
         r_gen   <= 1'b0;
         r_ack   <= 1'b0;
         r_miss  <= 1'b0;
      end else begin
         r_frame <= w_step ? w_stepped : w_postHit;
         r_gen   <= w_step;
         r_ack   <= w_hitFound;
         r_miss  <= w_step && w_bottomFull;
         if (en) begin
            r_cnt <= w_step ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   // Miss total sticks at all-ones once saturated.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_missCnt <= '0;
      end else if (w_step && w_bottomFull && (r_missCnt != '1)) begin
         r_missCnt <= r_missCnt + MISS_W'(1);
      end
   end

   assign Disp_num  = r_frame;
   assign gen_pulse = r_gen;
   assign hit_ack   = r_ack;
   assign miss      = r_miss;
   assign miss_cnt  = r_missCnt;

endmodule
